dual_grant_seq: RTL and testbench

Sequential grant issuer for the 12-request priority encoding path. It consumes a pair of 4-bit priority codes (highest and second-highest request, code k = request bit k-1, code 0 = none) and drives them back out as one-hot grants, one after another. Each grant is held until the granted requester acknowledges or a timeout expires. It sits downstream of the dual-priority encoder and returns serviced requests to one-hot form for the requesters.

---
 rtl/dual_grant_seq.sv | 148 ++++++++++++++
 tb/tb_dual_grant_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_grant_seq.sv
// dual_grant_seq: issues up to two one-hot grants in sequence from a pair of
// priority codes (code k = request bit k-1, 0 = none). Each grant is held
// until ack or until TIMEOUT grant cycles elapse without ack.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   start    capture first/second and begin a sequence (idle only)
//   first    highest-priority code, 0 = none
//   second   second-priority code, 0 = none
//   ack      granted requester done (sampled only while a grant is high)
//   grant    one-hot grant, bit (code-1)
//   grant_id code currently granted, 0 when no grant
//   busy     sequence in progress
//   timeout  one-cycle pulse: a grant ended without ack
//   done     one-cycle pulse: sequence complete
module dual_grant_seq #(
  parameter int unsigned N       = 12,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [3:0]   first,
  input  logic [3:0]   second,
  input  logic         ack,
  output logic [N-1:0] grant,
  output logic [3:0]   grant_id,
  output logic         busy,
  output logic         timeout,
  output logic         done
);

  localparam int unsigned CODEW = 4;
  localparam logic [CODEW-1:0] NCODE = CODEW'(N);
  localparam logic [CW-1:0]    TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_G1,
    S_GAP,
    S_G2,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CODEW-1:0] fst_q;
  logic [CODEW-1:0] sec_q;

  logic [CODEW-1:0] first_s_c;
  logic [CODEW-1:0] second_s_c;
  logic             grant_end_c;

  // Out-of-range codes map to "none"
  function automatic logic [CODEW-1:0] sanitize(input logic [CODEW-1:0] c);
    return (c > NCODE) ? '0 : c;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [CODEW-1:0] c);
    logic [N-1:0] v;
    v = '0;
    if (c != '0 && c <= NCODE) v = N'(1) << (c - CODEW'(1));
    return v;
  endfunction

  // Sanitised capture values; a duplicate second code collapses to none
  always_comb begin
    first_s_c  = sanitize(first);
    second_s_c = sanitize(second);
    if (second_s_c == first_s_c) second_s_c = '0;
  end

  // Grant ends on ack or on the last allowed grant cycle
  assign grant_end_c = ack || (cnt == TLAST);

  // Sequencer: state, counter, captured codes and all outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      fst_q    <= '0;
      sec_q    <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      done     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            fst_q <= first_s_c;
            sec_q <= second_s_c;
            cnt   <= '0;
            busy  <= 1'b1;
            if (first_s_c != '0) begin
              state    <= S_G1;
              grant    <= onehot(first_s_c);
              grant_id <= first_s_c;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_G1, S_G2: begin
          if (grant_end_c) begin
            grant    <= '0;
            grant_id <= '0;
            cnt      <= '0;
            // ack wins over a simultaneous timeout
            timeout  <= !ack;
            if (state == S_G1 && sec_q != '0) begin
              state <= S_GAP;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          cnt      <= '0;
          state    <= S_G2;
          grant    <= onehot(sec_q);
          grant_id <= sec_q;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          grant    <= '0;
          grant_id <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_grant_seq.sv
// tb_dual_grant_seq: drives directed and random sequences into dual_grant_seq
// and compares every cycle against a transaction-level model of the grant
// sequence (pending second code, grant hold count, gap/done flags).
module tb_dual_grant_seq;

  localparam int unsigned N       = 12;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CW      = 4;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [3:0]    first;
  logic [3:0]    second;
  logic          ack;
  logic [N-1:0]  grant;
  logic [3:0]    grant_id;
  logic          busy;
  logic          timeout;
  logic          done;

  int total = 0;
  int bad   = 0;
  logic armed = 1'b0;

  dual_grant_seq #(.N(N), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .first    (first),
    .second   (second),
    .ack      (ack),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after each edge
  typedef struct packed {
    logic        busy;
    logic [3:0]  gid;
    logic [31:0] held;
    logic        gap;
    logic [3:0]  pend;
    logic        done;
    logic        tmo;
  } model_t;

  model_t m = '0;

  function automatic model_t step_model(input model_t c, input logic rn,
                                        input logic st, input logic [3:0] f,
                                        input logic [3:0] s, input logic a);
    model_t n;
    int fs;
    int ss;
    n = c;
    if (!rn) return '0;
    n.tmo = 1'b0;
    if (c.done) begin
      n.done = 1'b0;
      n.busy = 1'b0;
    end else if (!c.busy) begin
      if (st) begin
        fs = (int'(f) >= 1 && int'(f) <= int'(N)) ? int'(f) : 0;
        ss = (int'(s) >= 1 && int'(s) <= int'(N)) ? int'(s) : 0;
        if (ss == fs) ss = 0;
        n.busy = 1'b1;
        n.pend = 4'(ss);
        if (fs == 0) n.done = 1'b1;
        else begin
          n.gid  = 4'(fs);
          n.held = 32'd1;
        end
      end
    end else if (c.gid != 4'd0) begin
      if (a || c.held == 32'(TIMEOUT)) begin
        n.tmo = !a;
        n.gid = 4'd0;
        if (c.pend != 4'd0) n.gap = 1'b1;
        else n.done = 1'b1;
      end else begin
        n.held = c.held + 32'd1;
      end
    end else if (c.gap) begin
      n.gap  = 1'b0;
      n.gid  = c.pend;
      n.pend = 4'd0;
      n.held = 32'd1;
    end
    return n;
  endfunction

  function automatic logic [N-1:0] exp_grant(input logic [3:0] id);
    if (id == 4'd0) return '0;
    return N'(1) << (id - 4'd1);
  endfunction

  always @(posedge clk) begin
    m     <= step_model(m, reset_n, start, first, second, ack);
    armed <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("model_grant", 32'(grant), 32'(exp_grant(m.gid)));
      chk("model_grant_id", 32'(grant_id), 32'(m.gid));
      chk("model_busy", 32'(busy), 32'(m.busy));
      chk("model_timeout", 32'(timeout), 32'(m.tmo));
      chk("model_done", 32'(done), 32'(m.done));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    first   = 4'd0;
    second  = 4'd0;
    ack     = 1'b0;

    // Reset and idle with stray ack
    for (int i = 0; i < 3; i++) begin
      ack = 1'(i);
      tick();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
    end
    reset_n = 1'b1;
    ack = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);
    ack = 1'b0;
    tick();
    chk("idle_grant", 32'(grant), 32'h0);

    // Normal pair, immediate acks
    start = 1'b1; first = 4'd12; second = 4'd5; ack = 1'b1;
    tick();
    start = 1'b0;
    chk("pair_c1_grant", 32'(grant), 32'h800);
    chk("pair_c1_id", 32'(grant_id), 32'd12);
    chk("pair_c1_busy", 32'(busy), 32'h1);
    tick();
    chk("pair_c2_grant", 32'(grant), 32'h0);
    tick();
    chk("pair_c3_grant", 32'(grant), 32'h010);
    chk("pair_c3_id", 32'(grant_id), 32'd5);
    tick();
    chk("pair_c4_done", 32'(done), 32'h1);
    tick();
    chk("pair_c5_busy", 32'(busy), 32'h0);

    // Timeout on single grant
    ack = 1'b0; start = 1'b1; first = 4'd3; second = 4'd0;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      chk("tmo_grant_held", 32'(grant), 32'h004);
      tick();
    end
    chk("tmo_grant_off", 32'(grant), 32'h0);
    chk("tmo_pulse", 32'(timeout), 32'h1);
    chk("tmo_done", 32'(done), 32'h1);
    tick();
    chk("tmo_idle_busy", 32'(busy), 32'h0);
    chk("tmo_pulse_off", 32'(timeout), 32'h0);

    // Degenerate codes
    start = 1'b1; first = 4'd0; second = 4'd7;
    tick();
    start = 1'b0;
    chk("f0_done", 32'(done), 32'h1);
    chk("f0_grant", 32'(grant), 32'h0);
    tick();
    chk("f0_idle", 32'(busy), 32'h0);
    start = 1'b1; first = 4'd14; second = 4'd2;
    tick();
    start = 1'b0;
    chk("f14_done", 32'(done), 32'h1);
    chk("f14_id", 32'(grant_id), 32'h0);
    tick();
    ack = 1'b1; start = 1'b1; first = 4'd4; second = 4'd4;
    tick();
    start = 1'b0;
    chk("dup_grant", 32'(grant), 32'h008);
    tick();
    chk("dup_done", 32'(done), 32'h1);
    chk("dup_nogrant", 32'(grant), 32'h0);
    tick();
    chk("dup_idle", 32'(busy), 32'h0);

    // Ack on the last grant cycle, start pulsed while busy
    ack = 1'b0; start = 1'b1; first = 4'd6; second = 4'd9;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      chk("col_grant", 32'(grant), 32'h020);
      ack   = (k == 15);
      start = (k == 3);
      if (k == 3) begin first = 4'd1; second = 4'd1; end
      tick();
    end
    chk("col_no_tmo", 32'(timeout), 32'h0);
    chk("col_gap", 32'(grant), 32'h0);
    ack = 1'b1;
    tick();
    chk("col_g2_grant", 32'(grant), 32'h100);
    chk("col_g2_id", 32'(grant_id), 32'd9);
    tick();
    chk("col_done", 32'(done), 32'h1);
    ack = 1'b0;
    tick();

    // Reset during second grant
    ack = 1'b1; start = 1'b1; first = 4'd2; second = 4'd11;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rmid_g2", 32'(grant), 32'h400);
    reset_n = 1'b0; ack = 1'b0;
    tick();
    chk("rmid_grant", 32'(grant), 32'h0);
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_done", 32'(done), 32'h0);
    reset_n = 1'b1;
    tick();
    start = 1'b1; first = 4'd7; second = 4'd0; ack = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_grant", 32'(grant), 32'h040);
    chk("post_rst_id", 32'(grant_id), 32'd7);
    tick();
    chk("post_rst_done", 32'(done), 32'h1);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      start   = ($urandom_range(0, 3) == 0);
      first   = 4'($urandom_range(0, 15));
      second  = ($urandom_range(0, 7) == 0) ? first : 4'($urandom_range(0, 15));
      ack     = ($urandom_range(0, 9) == 0);
      tick();
    end

    reset_n = 1'b1; start = 1'b0; ack = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
